quad_enc_emulator: RTL



---
 rtl/quad_emu_pkg.sv | 45 ++++
 rtl/pwm_duty_meter.sv | 52 +++++
 rtl/quad_enc_emulator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/quad_emu_pkg.sv
// Shared types and quadrature phase helpers for the encoder emulator.
// Phases are stored as {A,B}; forward walks 00 -> 10 -> 11 -> 01 -> 00.
package quad_emu_pkg;

    typedef enum logic [1:0] {
        FWD,
        REV,
        BRAKE
    } dir_e;

    typedef enum logic {
        IDLE,
        RUN
    } step_state_e;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    function automatic logic [1:0] phase_next(input logic [1:0] ph);
        case (ph)
            PH_00:   return PH_10;
            PH_10:   return PH_11;
            PH_11:   return PH_01;
            default: return PH_00;
        endcase
    endfunction

    function automatic logic [1:0] phase_prev(input logic [1:0] ph);
        case (ph)
            PH_00:   return PH_01;
            PH_01:   return PH_11;
            PH_11:   return PH_10;
            default: return PH_00;
        endcase
    endfunction

    function automatic dir_e decode_dir(input logic dir_1, input logic dir_2);
        if (dir_1 && !dir_2) return FWD;
        if (!dir_1 && dir_2) return REV;
        return BRAKE;
    endfunction

endpackage

// File: rtl/pwm_duty_meter.sv
// Synchronises the gated PWM pin and counts its high cycles over a fixed
// power-of-two window; the count (0..PWM_WINDOW) is latched at window end.
module pwm_duty_meter #(
    parameter int PWM_WINDOW = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pwm,
    output logic [$clog2(PWM_WINDOW):0] duty,
    output logic                        window_done
);

    localparam int CW = $clog2(PWM_WINDOW);
    localparam int DW = CW + 1;

    logic [1:0]    pwm_sync_q;
    logic          pwm_s;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic [DW-1:0] high_cnt_q, high_cnt_d;
    logic [DW-1:0] duty_q, duty_d;

    assign pwm_s       = pwm_sync_q[1];
    assign window_done = (win_cnt_q == CW'(PWM_WINDOW - 1));
    assign duty        = duty_q;

    // The last window cycle is included in the latched count.
    always_comb begin
        high_cnt_d = high_cnt_q + DW'(pwm_s);
        win_cnt_d  = win_cnt_q + 1'b1;
        duty_d     = duty_q;
        if (window_done) begin
            duty_d     = high_cnt_d;
            high_cnt_d = '0;
            win_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_sync_q <= '0;
            win_cnt_q  <= '0;
            high_cnt_q <= '0;
            duty_q     <= '0;
        end else begin
            pwm_sync_q <= {pwm_sync_q[0], pwm};
            win_cnt_q  <= win_cnt_d;
            high_cnt_q <= high_cnt_d;
            duty_q     <= duty_d;
        end
    end

endmodule

// File: rtl/quad_enc_emulator.sv
// Motor + quadrature encoder stand-in: integrates measured PWM duty into steps
// and emits A/B phases and a tracked position bounded by end stops.
module quad_enc_emulator
    import quad_emu_pkg::*;
#(
    parameter int PWM_WINDOW = 256,
    parameter int STEP_DIV   = 1024,
    parameter int POS_INIT   = 0,
    parameter int POS_MIN    = -16,
    parameter int POS_MAX    = 20000
) (
    input  logic        CLK100MHZ,
    input  logic        RESET,
    input  logic        EN,
    input  logic        DIR_1,
    input  logic        DIR_2,
    input  logic        PWM,
    input  logic        LOAD,
    input  logic [31:0] LOAD_POS,
    output logic        ENC_1,
    output logic        ENC_2,
    output logic [31:0] POS,
    output logic        STEP_PULSE,
    output logic        STALL
);

    localparam int DUTY_W = $clog2(PWM_WINDOW) + 1;
    localparam int ACC_W  = $clog2(STEP_DIV + PWM_WINDOW) + 1;

    logic [DUTY_W-1:0] duty;
    logic              unused_window_done;

    pwm_duty_meter #(
        .PWM_WINDOW(PWM_WINDOW)
    ) u_duty (
        .clk        (CLK100MHZ),
        .rst        (RESET),
        .pwm        (PWM),
        .duty       (duty),
        .window_done(unused_window_done)
    );

    logic [1:0]         dir_meta_q, dir_sync_q;
    step_state_e        state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic [1:0]         phase_q, phase_d;
    logic signed [31:0] pos_q, pos_d, load_pos;
    logic               pulse_q, pulse_d;
    logic               stall_q, stall_d;
    dir_e               dir;
    logic               fwd, step_req, blocked_cur, blocked_load;

    assign load_pos = LOAD_POS;

    always_comb begin
        dir      = decode_dir(dir_sync_q[0], dir_sync_q[1]);
        fwd      = (dir == FWD);
        state_d  = (EN && dir != BRAKE) ? RUN : IDLE;
        acc_sum  = acc_q + ACC_W'(duty);
        acc_d    = '0;
        step_req = 1'b0;
        if (state_d == RUN) begin
            if (acc_sum >= ACC_W'(STEP_DIV)) begin
                step_req = 1'b1;
                acc_d    = acc_sum - ACC_W'(STEP_DIV);
            end else begin
                acc_d = acc_sum;
            end
        end

        blocked_cur  = fwd ? (pos_q >= POS_MAX) : (pos_q <= POS_MIN);
        blocked_load = fwd ? (load_pos >= POS_MAX) : (load_pos <= POS_MIN);

        pos_d   = pos_q;
        phase_d = phase_q;
        pulse_d = 1'b0;
        stall_d = stall_q;
        // LOAD swallows a coincident step but the accumulator still pays for it.
        if (LOAD) begin
            pos_d   = load_pos;
            stall_d = (stall_q || step_req) && blocked_load;
        end else if (step_req) begin
            if (blocked_cur) begin
                stall_d = 1'b1;
            end else begin
                pos_d   = fwd ? pos_q + 32'sd1 : pos_q - 32'sd1;
                phase_d = fwd ? phase_next(phase_q) : phase_prev(phase_q);
                pulse_d = 1'b1;
                stall_d = 1'b0;
            end
        end
        if (state_d == IDLE && state_q == RUN) begin
            stall_d = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            dir_meta_q <= '0;
            dir_sync_q <= '0;
            state_q    <= IDLE;
            acc_q      <= '0;
            phase_q    <= PH_00;
            pos_q      <= POS_INIT;
            pulse_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            dir_meta_q <= {DIR_2, DIR_1};
            dir_sync_q <= dir_meta_q;
            state_q    <= state_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            pulse_q    <= pulse_d;
            stall_q    <= stall_d;
        end
    end

    assign ENC_1      = phase_q[1];
    assign ENC_2      = phase_q[0];
    assign POS        = pos_q;
    assign STEP_PULSE = pulse_q;
    assign STALL      = stall_q;

endmodule
